// File: rtl/predictor_arbiter.sv
// Arbitrates the single predictor access point between fetch predictions and
// buffered commit feedback, with a starvation bound on the feedback side.
module predictor_arbiter #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned FIFO_DEPTH_WIDTH = 2,
  parameter int unsigned STARVE_LIMIT     = 4
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFPA_predict_req,
  input  logic [ADDR_WIDTH-1:0] IFPA_pc,
  output logic                  PAIF_predict_valid,
  output logic                  PAIF_predict_result,
  input  logic                  ROBPA_feedback_en,
  input  logic [ADDR_WIDTH-1:0] ROBPA_feedback_pc,
  input  logic                  ROBPA_branch_result,
  output logic                  PAROB_full,
  output logic                  PAPD_predict_en,
  output logic [ADDR_WIDTH-1:0] PAPD_pc,
  output logic                  PAPD_feedback_en,
  output logic [ADDR_WIDTH-1:0] PAPD_feedback_pc,
  output logic                  PAPD_branch_result,
  input  logic                  PDPA_predict_result
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_WIDTH;
  localparam int unsigned CntW  = FIFO_DEPTH_WIDTH + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] pc_mem  [Depth];
  logic                  res_mem [Depth];

  logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [3:0]                  starve_q, starve_d;
  logic                        valid_q, valid_d;
  logic                        result_q, result_d;

  logic empty, full, force_fb, predict_grant, feedback_grant, push, pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DepthCnt);
    force_fb = (starve_q == StarveMax) && !empty;
    // Reset gates the enables so the predictor never sees a partial update.
    predict_grant  = Sys_rdy && !Sys_rst && IFPA_predict_req && !force_fb;
    feedback_grant = Sys_rdy && !Sys_rst && !empty && !predict_grant;
    push = Sys_rdy && ROBPA_feedback_en && !full;
    pop  = feedback_grant;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (push) wr_ptr_d = wr_ptr_q + FIFO_DEPTH_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_DEPTH_WIDTH'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
    if (Sys_rdy) begin
      if (empty || feedback_grant)  starve_d = '0;
      else if (starve_q < StarveMax) starve_d = starve_q + 4'd1;
    end
    valid_d  = predict_grant;
    result_d = predict_grant ? PDPA_predict_result : result_q;
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      valid_q  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge Sys_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= ROBPA_feedback_pc;
      res_mem[wr_ptr_q] <= ROBPA_branch_result;
    end
  end

  assign PAIF_predict_valid  = valid_q;
  assign PAIF_predict_result = result_q;
  assign PAROB_full          = full;
  assign PAPD_predict_en     = predict_grant;
  assign PAPD_pc             = IFPA_pc;
  assign PAPD_feedback_en    = feedback_grant;
  assign PAPD_feedback_pc    = pc_mem[rd_ptr_q];
  assign PAPD_branch_result  = res_mem[rd_ptr_q];

endmodule

// File: tb/tb_predictor_arbiter.sv
// Directed bench for predictor_arbiter: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_predictor_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 4;

  logic          clk, rst, rdy;
  logic          req, pdpa;
  logic [AW-1:0] ifpc, fbpc;
  logic          fb_en, fb_res;
  logic          valid, result, full;
  logic          pd_pen, pd_fen, pd_bres;
  logic [AW-1:0] pd_pc, pd_fpc;

  int errs   = 0;
  int checks = 0;

  predictor_arbiter #(
    .ADDR_WIDTH      (AW),
    .FIFO_DEPTH_WIDTH(2),
    .STARVE_LIMIT    (LIMIT)
  ) dut (
    .Sys_clk            (clk),
    .Sys_rst            (rst),
    .Sys_rdy            (rdy),
    .IFPA_predict_req   (req),
    .IFPA_pc            (ifpc),
    .PAIF_predict_valid (valid),
    .PAIF_predict_result(result),
    .ROBPA_feedback_en  (fb_en),
    .ROBPA_feedback_pc  (fbpc),
    .ROBPA_branch_result(fb_res),
    .PAROB_full         (full),
    .PAPD_predict_en    (pd_pen),
    .PAPD_pc            (pd_pc),
    .PAPD_feedback_en   (pd_fen),
    .PAPD_feedback_pc   (pd_fpc),
    .PAPD_branch_result (pd_bres),
    .PDPA_predict_result(pdpa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, starvation as an integer age.
  typedef struct {
    logic [AW-1:0] pc;
    logic          res;
  } ent_t;

  ent_t m_q[$];
  int   m_starve = 0;
  logic m_valid  = 1'b0;
  logic m_result = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", AW'(valid), 0);
      chk("rst_result", AW'(result), 0);
      chk("rst_full", AW'(full), 0);
      chk("rst_pen", AW'(pd_pen), 0);
      chk("rst_fen", AW'(pd_fen), 0);
      m_q.delete();
      m_starve = 0;
      m_valid  = 1'b0;
      m_result = 1'b0;
    end else begin
      bit   nonempty, frc, pg, fg, can_push;
      ent_t e;
      nonempty = (m_q.size() != 0);
      frc = rdy && (m_starve == LIMIT) && nonempty;
      pg  = rdy && req && !frc;
      fg  = rdy && nonempty && !pg;
      chk("m_pen", AW'(pd_pen), AW'(pg));
      chk("m_fen", AW'(pd_fen), AW'(fg));
      chk("m_pc", pd_pc, ifpc);
      chk("m_full", AW'(full), AW'(m_q.size() == DEPTH));
      chk("m_valid", AW'(valid), AW'(m_valid));
      chk("m_result", AW'(result), AW'(m_result));
      if (fg) begin
        chk("m_fpc", pd_fpc, m_q[0].pc);
        chk("m_bres", AW'(pd_bres), AW'(m_q[0].res));
      end
      if (rdy) begin
        can_push = fb_en && (m_q.size() < DEPTH);
        if (!nonempty || fg) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        m_valid = pg;
        if (pg) m_result = pdpa;
        if (fg) void'(m_q.pop_front());
        if (can_push) begin
          e.pc  = fbpc;
          e.res = fb_res;
          m_q.push_back(e);
        end
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_off();
    fb_en = 1'b0; fbpc = '0; fb_res = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; req = 1'b1; pdpa = 1'b0; ifpc = 32'h55;
    push_off();
    #2 rst = 1'b1;
    cyc(); #1;
    chk("reset_pen_gated", AW'(pd_pen), 0);
    chk("reset_valid", AW'(valid), 0);
    cyc();
    rst = 1'b0; req = 1'b0; ifpc = '0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("idle_valid", AW'(valid), 0);
      chk("idle_full", AW'(full), 0);
      chk("idle_fen", AW'(pd_fen), 0);
    end

    // Idle-predictor feedback
    cyc(); fb_en = 1'b1; fbpc = 32'h1000; fb_res = 1'b1; #1;
    chk("fb_c0_fen", AW'(pd_fen), 0);
    cyc(); push_off(); #1;
    chk("fb_c1_fen", AW'(pd_fen), 1);
    chk("fb_c1_pc", pd_fpc, 32'h1000);
    chk("fb_c1_res", AW'(pd_bres), 1);
    cyc(); #1;
    chk("fb_c2_fen", AW'(pd_fen), 0);

    // Prediction path
    cyc(); req = 1'b1; ifpc = 32'h2004; pdpa = 1'b1; #1;
    chk("pr_c0_pen", AW'(pd_pen), 1);
    chk("pr_c0_pc", pd_pc, 32'h2004);
    cyc(); req = 1'b0; pdpa = 1'b0; #1;
    chk("pr_c1_valid", AW'(valid), 1);
    chk("pr_c1_result", AW'(result), 1);
    cyc(); #1;
    chk("pr_c2_valid", AW'(valid), 0);
    chk("pr_c2_hold", AW'(result), 1);

    // Starvation bound
    cyc(); req = 1'b1; ifpc = 32'h3000; pdpa = 1'b0;
    fb_en = 1'b1; fbpc = 32'h4000; fb_res = 1'b0; #1;
    chk("st_c0_pen", AW'(pd_pen), 1);
    for (int c = 1; c <= 4; c++) begin
      cyc(); push_off(); #1;
      chk("st_pen", AW'(pd_pen), 1);
      chk("st_fen", AW'(pd_fen), 0);
    end
    cyc(); #1;
    chk("st_c5_pen", AW'(pd_pen), 0);
    chk("st_c5_fen", AW'(pd_fen), 1);
    chk("st_c5_pc", pd_fpc, 32'h4000);
    cyc(); #1;
    chk("st_c6_valid", AW'(valid), 0);
    chk("st_c6_pen", AW'(pd_pen), 1);
    cyc(); req = 1'b0;

    // Full, dropped pushes and in-order drain
    for (int c = 0; c < 5; c++) begin
      cyc(); req = 1'b1; ifpc = 32'h9000;
      fb_en = 1'b1; fbpc = AW'(c + 1); fb_res = c[0]; #1;
      chk("fill_full", AW'(full), AW'(c == 4));
    end
    cyc(); fbpc = 32'h6; #1;  // push while full and popping: dropped
    chk("fill_c5_fen", AW'(pd_fen), 1);
    chk("fill_c5_pc", pd_fpc, 32'h1);
    chk("fill_c5_full", AW'(full), 1);
    cyc(); push_off(); req = 1'b0; #1;
    chk("drain_full_low", AW'(full), 0);
    for (int p = 2; p <= 4; p++) begin
      if (p > 2) begin cyc(); #1; end
      chk("drain_fen", AW'(pd_fen), 1);
      chk("drain_pc", pd_fpc, AW'(p));
    end
    cyc(); #1;
    chk("drain_empty", AW'(pd_fen), 0);

    // Second fill across the pointer wrap
    for (int c = 0; c < 4; c++) begin
      cyc(); req = 1'b1; fb_en = 1'b1; fbpc = AW'(32'h11 + c); fb_res = 1'b1;
    end
    cyc(); push_off(); #1;
    chk("wrap_full", AW'(full), 1);
    chk("wrap_pen", AW'(pd_pen), 1);
    cyc(); req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      #1;
      chk("wrap_pc", pd_fpc, AW'(32'h11 + c));
    end
    cyc(); #1;
    chk("wrap_empty", AW'(pd_fen), 0);

    // Sys_rdy freeze
    for (int c = 0; c < 3; c++) begin
      cyc(); rdy = 1'b0; req = 1'b1; ifpc = 32'h5000; pdpa = 1'b1;
      fb_en = 1'b1; fbpc = 32'h6000; fb_res = 1'b1; #1;
      chk("frz_pen", AW'(pd_pen), 0);
      chk("frz_fen", AW'(pd_fen), 0);
      if (c > 0) chk("frz_valid", AW'(valid), 0);
    end
    cyc(); rdy = 1'b1; push_off(); #1;
    chk("frz_rel_pen", AW'(pd_pen), 1);
    cyc(); req = 1'b0; pdpa = 1'b0; #1;
    chk("frz_valid_out", AW'(valid), 1);
    chk("frz_result_out", AW'(result), 1);
    chk("frz_no_push", AW'(pd_fen), 0);

    // Reset mid-operation
    cyc(); req = 1'b1; ifpc = 32'h7000; pdpa = 1'b1;
    fb_en = 1'b1; fbpc = 32'h8000; fb_res = 1'b1;
    cyc(); push_off(); #1;
    chk("mid_valid_pre", AW'(valid), 1);
    rst = 1'b1; #1;
    chk("mid_valid_rst", AW'(valid), 0);
    chk("mid_pen_rst", AW'(pd_pen), 0);
    chk("mid_fen_rst", AW'(pd_fen), 0);
    cyc(); rst = 1'b0; req = 1'b0; #1;
    chk("mid_discard", AW'(pd_fen), 0);
    cyc(); cyc(); #1;
    chk("mid_valid_post", AW'(valid), 0);

    cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
